adc_acq_sched: RTL and testbench

- Sequences the shared serial-ADC front end (ADC model or real ADC) between N_REQ requesters.
- Grants bursts of BURST_LEN samples per request, round-robin. Drives the ADC `start` level and captures each sample frame.
- Returns samples tagged with requester ID and a last-sample flag. A watchdog flags a stalled ADC.
- Sits between the ADC block and the per-channel processing/DSP consumers.

---
 rtl/adc_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/adc_acq_sched.sv | 168 ++++++++++++++++
 tb/tb_adc_acq_sched.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC acquisition scheduler: FSM state encoding,
// the ADC frame length and default parameter values.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    GAP   = 2'd2,
    ABORT = 2'd3
  } acq_state_e;

  // One serial conversion frame of the ADC, in clk_100 cycles.
  localparam int ADC_FRAME_CYC   = 19;

  localparam int DEF_N_REQ       = 2;
  localparam int DEF_DW          = 16;
  localparam int DEF_BURST_LEN   = 8;
  localparam int DEF_GAP_CYC     = 4;
  localparam int DEF_TIMEOUT_CYC = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping around.
//   req_i  : request vector
//   ptr_i  : index with highest priority this round
//   gnt_o  : one-hot winner (zero when no request)
//   idx_o  : binary index of the winner
//   vld_o  : any request present
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [1:0]       ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [1:0]       idx_o,
  output logic             vld_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    // k is the distance from the pointer; the first hit wins.
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!vld_o && req_i[i] && (i == (int'(ptr_i) + k) % N_REQ)) begin
          vld_o    = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = 2'(i);
        end
      end
    end
  end

endmodule

// File: rtl/adc_acq_sched.sv
// Shares one serial ADC between N_REQ requesters. Each grant runs the ADC for
// a burst of BURST_LEN samples, then a GAP_CYC idle gap lets the ADC reset
// before the next round-robin arbitration. A watchdog aborts a burst when no
// valid sample arrives within TIMEOUT_CYC cycles.
//   clk_100, reset       : clock, synchronous active-high reset
//   req / grant          : level requests, one-hot grant held for the burst
//   adc_start            : ADC run enable
//   adc_cs/adc_en/adc_data : ADC frame end (cs rise), data valid, data
//   smp_*                : captured sample, requester id, strobe, last flag
//   busy                 : not IDLE
//   timeout_err, err_clr : sticky watchdog flag and its clear
module adc_acq_sched
  import adc_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int DW          = DEF_DW,
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int GAP_CYC     = DEF_GAP_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk_100,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             adc_start,
  input  logic             adc_cs,
  input  logic             adc_en,
  input  logic [DW-1:0]    adc_data,
  output logic [DW-1:0]    smp_data,
  output logic [1:0]       smp_id,
  output logic             smp_valid,
  output logic             smp_last,
  output logic             busy,
  output logic             timeout_err,
  input  logic             err_clr
);

  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW  = $clog2(GAP_CYC + 1);

  acq_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [1:0]       idx_q, idx_d, ptr_q, ptr_d;
  logic             start_q, start_d, cs_q;
  logic [7:0]       cnt_q, cnt_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [DW-1:0]    smp_data_q, smp_data_d;
  logic [1:0]       smp_id_q, smp_id_d;
  logic             smp_valid_q, smp_valid_d, smp_last_q, smp_last_d;
  logic             err_q, err_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [1:0]       arb_idx;
  logic             arb_vld;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  // A frame ends on the cs rising edge; it only counts with data valid.
  logic smp_evt, last_hit, wd_exp, req_own;
  assign smp_evt  = (state_q == RUN) && adc_cs && !cs_q && adc_en;
  assign last_hit = smp_evt && (cnt_q + 8'd1 == 8'(BURST_LEN));
  assign wd_exp   = !smp_evt && (wd_q == WDW'(TIMEOUT_CYC - 1));
  assign req_own  = |(req & grant_q);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    start_d     = start_q;
    cnt_d       = cnt_q;
    wd_d        = wd_q;
    gcnt_d      = gcnt_q;
    smp_data_d  = smp_data_q;
    smp_id_d    = smp_id_q;
    smp_valid_d = 1'b0;
    smp_last_d  = 1'b0;
    // A timeout in the same cycle overrides the clear below.
    err_d       = err_q & ~err_clr;
    unique case (state_q)
      IDLE: begin
        if (arb_vld) begin
          state_d = RUN;
          grant_d = arb_gnt;
          idx_d   = arb_idx;
          ptr_d   = (arb_idx == 2'(N_REQ - 1)) ? 2'd0 : arb_idx + 2'd1;
          start_d = 1'b1;
          cnt_d   = '0;
          wd_d    = '0;
        end
      end
      RUN: begin
        wd_d = wd_q + WDW'(1);
        if (smp_evt) begin
          smp_data_d  = adc_data;
          smp_id_d    = idx_q;
          smp_valid_d = 1'b1;
          smp_last_d  = last_hit;
          cnt_d       = cnt_q + 8'd1;
          wd_d        = '0;
        end
        // Burst ends on the last sample, a withdrawn request or a stall.
        if (last_hit || !req_own || wd_exp) begin
          state_d = wd_exp ? ABORT : GAP;
          grant_d = '0;
          start_d = 1'b0;
          gcnt_d  = '0;
          if (wd_exp) err_d = 1'b1;
        end
      end
      GAP, ABORT: begin
        if (gcnt_q == GW'(GAP_CYC - 1)) state_d = IDLE;
        else                            gcnt_d  = gcnt_q + GW'(1);
      end
    endcase
  end

  always_ff @(posedge clk_100) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      idx_q       <= '0;
      ptr_q       <= '0;
      start_q     <= 1'b0;
      cs_q        <= 1'b0;
      cnt_q       <= '0;
      wd_q        <= '0;
      gcnt_q      <= '0;
      smp_data_q  <= '0;
      smp_id_q    <= '0;
      smp_valid_q <= 1'b0;
      smp_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      start_q     <= start_d;
      cs_q        <= adc_cs;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
      gcnt_q      <= gcnt_d;
      smp_data_q  <= smp_data_d;
      smp_id_q    <= smp_id_d;
      smp_valid_q <= smp_valid_d;
      smp_last_q  <= smp_last_d;
      err_q       <= err_d;
    end
  end

  assign grant       = grant_q;
  assign adc_start   = start_q;
  assign smp_data    = smp_data_q;
  assign smp_id      = smp_id_q;
  assign smp_valid   = smp_valid_q;
  assign smp_last    = smp_last_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = err_q;

endmodule

// File: tb/tb_adc_acq_sched.sv
// Directed bench for adc_acq_sched. Two instances share one behavioural ADC:
// u4 (BURST_LEN=4) for single-requester, timeout, drop and reset cases,
// u2 (BURST_LEN=2) for round-robin alternation.
module tb_adc_acq_sched;
  import adc_pkg::*;

  localparam int DW = 16;

  logic clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  logic          reset;
  logic [1:0]    req4, req2, grant4, grant2;
  logic          start4, start2;
  logic          adc_cs, adc_en;
  logic [DW-1:0] adc_data;
  logic [DW-1:0] sd4, sd2;
  logic [1:0]    sid4, sid2;
  logic          sv4, sv2, sl4, sl2, busy4, busy2, terr4, terr2, clr4, clr2;

  adc_acq_sched #(.N_REQ(2), .DW(DW), .BURST_LEN(4), .GAP_CYC(4), .TIMEOUT_CYC(64)) u4 (
    .clk_100(clk_100), .reset(reset), .req(req4), .grant(grant4), .adc_start(start4),
    .adc_cs(adc_cs), .adc_en(adc_en), .adc_data(adc_data),
    .smp_data(sd4), .smp_id(sid4), .smp_valid(sv4), .smp_last(sl4),
    .busy(busy4), .timeout_err(terr4), .err_clr(clr4));

  adc_acq_sched #(.N_REQ(2), .DW(DW), .BURST_LEN(2), .GAP_CYC(4), .TIMEOUT_CYC(64)) u2 (
    .clk_100(clk_100), .reset(reset), .req(req2), .grant(grant2), .adc_start(start2),
    .adc_cs(adc_cs), .adc_en(adc_en), .adc_data(adc_data),
    .smp_data(sd2), .smp_id(sid2), .smp_valid(sv2), .smp_last(sl2),
    .busy(busy2), .timeout_err(terr2), .err_clr(clr2));

  // ADC model: cs idles high, drops while converting, rises for one cycle at
  // each frame end. Stall keeps cs low; en_ok=0 makes edges invalid.
  logic          sel2, adc_stall, adc_en_ok, adc_run;
  logic [DW-1:0] ramp;
  int            fcnt;
  assign adc_run = sel2 ? start2 : start4;

  always @(negedge clk_100) begin
    if (!adc_run) begin
      fcnt = 0; adc_cs = 1'b1; adc_en = 1'b0;
    end else if (fcnt == ADC_FRAME_CYC - 1) begin
      fcnt   = 0;
      adc_cs = !adc_stall;
      adc_en = adc_en_ok;
      if (adc_en_ok && !adc_stall) begin
        ramp     = ramp + 1'b1;
        adc_data = ramp;
      end
    end else begin
      fcnt = fcnt + 1; adc_cs = 1'b0; adc_en = 1'b0;
    end
  end

  // Sample logs
  int            cyc = 0;
  always @(posedge clk_100) cyc <= cyc + 1;

  logic [DW-1:0] q4d[$], q2d[$];
  logic [1:0]    q4i[$], q2i[$], g2seq[$];
  logic          q4l[$], q2l[$];
  int            q4c[$];
  logic [1:0]    g2prev = 2'b00;
  int            multi = 0;

  always @(negedge clk_100) begin
    if (sv4 === 1'b1) begin
      q4d.push_back(sd4); q4i.push_back(sid4); q4l.push_back(sl4); q4c.push_back(cyc);
    end
    if (sv2 === 1'b1) begin
      q2d.push_back(sd2); q2i.push_back(sid2); q2l.push_back(sl2);
    end
    if (grant2 !== g2prev && grant2 != 2'b00) g2seq.push_back(grant2);
    g2prev = grant2;
    if ($countones(grant4) > 1 || $countones(grant2) > 1) multi++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_100);
      #2;
    end
  endtask

  int n, base, gcyc;
  logic any_last;
  logic [1:0] exp_id2 [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0};

  initial begin
    reset = 1'b1; req4 = '0; req2 = '0; clr4 = 1'b0; clr2 = 1'b0;
    sel2 = 1'b0; adc_stall = 1'b0; adc_en_ok = 1'b1; ramp = '0;
    adc_cs = 1'b1; adc_en = 1'b0; adc_data = '0;
    tick(3);
    chk("rst_grant", grant4, 0);
    chk("rst_start", start4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_valid", sv4, 0);
    chk("rst_err", terr4, 0);
    chk("rst_data", sd4, 0);
    chk("rst_start2", start2, 0);
    reset = 1'b0;
    tick(1);

    // Single requester, 4-sample burst with ramp data
    req4 = 2'b01;
    tick(1);
    gcyc = cyc;
    chk("t1_grant", grant4, 2'b01);
    chk("t1_start", start4, 1);
    chk("t1_busy", busy4, 1);
    n = 0;
    while (start4 && n < 200) begin tick(1); n++; end
    chk("t1_burst_end", start4, 0);
    chk("t1_last_strobe", {sv4, sl4}, 2'b11);
    chk("t1_grant_off", grant4, 0);
    req4 = '0;
    tick(3);
    chk("t1_gap_busy", busy4, 1);
    chk("t1_gap_start", start4, 0);
    tick(1);
    chk("t1_idle", busy4, 0);
    chk("t1_nsmp", q4d.size(), 4);
    chk("t1_first_lat", q4c[0] - gcyc, 19);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_data%0d", i), q4d[i], i + 1);
      chk($sformatf("t1_id%0d", i), q4i[i], 0);
      chk($sformatf("t1_last%0d", i), q4l[i], (i == 3));
      if (i > 0) chk($sformatf("t1_space%0d", i), q4c[i] - q4c[i-1], 19);
    end

    // Both requesters held, 2-sample bursts alternate
    sel2 = 1'b1; ramp = '0; req2 = 2'b11;
    n = 0;
    while (q2d.size() < 6 && n < 600) begin tick(1); n++; end
    req2 = '0;
    tick(10);
    chk("t2_nsmp", q2d.size(), 6);
    chk("t2_idle", busy2, 0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t2_id%0d", i), q2i[i], exp_id2[i]);
      chk($sformatf("t2_last%0d", i), q2l[i], (i % 2 == 1));
      chk($sformatf("t2_data%0d", i), q2d[i], i + 1);
    end
    chk("t2_ngrants", g2seq.size(), 3);
    chk("t2_g0", g2seq[0], 2'b01);
    chk("t2_g1", g2seq[1], 2'b10);
    chk("t2_g2", g2seq[2], 2'b01);

    // Stalled ADC: watchdog expires 64 cycles after grant
    sel2 = 1'b0; adc_stall = 1'b1; req4 = 2'b01;
    tick(1);
    chk("t3_grant", grant4, 2'b01);
    n = 0;
    while (!terr4 && n < 200) begin tick(1); n++; end
    chk("t3_wd_cycles", n, 64);
    chk("t3_grant_off", grant4, 0);
    chk("t3_start_off", start4, 0);
    chk("t3_abort_busy", busy4, 1);
    req4 = '0;
    tick(10);
    chk("t3_sticky", terr4, 1);
    chk("t3_idle", busy4, 0);
    clr4 = 1'b1; tick(1); clr4 = 1'b0;
    chk("t3_cleared", terr4, 0);

    // Edges with adc_en low are ignored and do not feed the watchdog
    adc_stall = 1'b0; adc_en_ok = 1'b0; base = q4d.size(); req4 = 2'b01;
    tick(1);
    chk("t6_grant", grant4, 2'b01);
    n = 0;
    while (!terr4 && n < 200) begin tick(1); n++; end
    chk("t6_wd_cycles", n, 64);
    chk("t6_no_smp", q4d.size() - base, 0);
    req4 = '0;
    tick(6);

    // Clear coinciding with a new timeout leaves the flag set
    adc_stall = 1'b1; adc_en_ok = 1'b1; req4 = 2'b01;
    tick(1);
    tick(63);
    chk("t7_still_run", start4, 1);
    clr4 = 1'b1; tick(1); clr4 = 1'b0;
    chk("t7_set_wins", terr4, 1);
    chk("t7_aborted", start4, 0);
    req4 = '0;
    clr4 = 1'b1; tick(1); clr4 = 1'b0;
    chk("t7_cleared", terr4, 0);
    tick(6);

    // Request withdrawn after 2 samples
    adc_stall = 1'b0; ramp = '0; base = q4d.size(); req4 = 2'b01;
    tick(1);
    chk("t4_grant", grant4, 2'b01);
    n = 0;
    while (q4d.size() - base < 2 && n < 200) begin tick(1); n++; end
    req4 = '0;
    tick(1);
    chk("t4_start_off", start4, 0);
    chk("t4_grant_off", grant4, 0);
    chk("t4_gap_busy", busy4, 1);
    tick(30);
    n = q4d.size() - base;
    chk("t4_at_most_one_more", (n == 2 || n == 3), 1);
    any_last = 1'b0;
    for (int i = base; i < q4d.size(); i++) any_last |= q4l[i];
    chk("t4_no_last", any_last, 0);
    chk("t4_idle", busy4, 0);

    // Reset in the middle of a burst (pointer sits at requester 1)
    ramp = '0; base = q4d.size(); req4 = 2'b11;
    tick(1);
    chk("t5_grant_rr", grant4, 2'b10);
    n = 0;
    while (q4d.size() - base < 3 && n < 200) begin tick(1); n++; end
    reset = 1'b1;
    tick(1);
    chk("t5_grant", grant4, 0);
    chk("t5_start", start4, 0);
    chk("t5_busy", busy4, 0);
    chk("t5_valid", sv4, 0);
    chk("t5_last", sl4, 0);
    chk("t5_data", sd4, 0);
    chk("t5_id", sid4, 0);
    chk("t5_err", terr4, 0);
    ramp = '0; base = q4d.size(); reset = 1'b0;
    tick(1);
    chk("t5_regrant", grant4, 2'b01);
    n = 0;
    while (start4 && n < 200) begin tick(1); n++; end
    chk("t5_burst_end", {start4, sl4}, 2'b01);
    req4 = '0;
    tick(6);
    chk("t5_nsmp", q4d.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_id%0d", i), q4i[base+i], 0);
      chk($sformatf("t5_data%0d", i), q4d[base+i], i + 1);
      chk($sformatf("t5_lastf%0d", i), q4l[base+i], (i == 3));
    end

    chk("onehot_grant", multi, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
